npu_add_tree_feeder: RTL and testbench

- Operand sequencer and accumulator on the issue side of the NPU 8-lane int8 add tree.
- Per job: reads `cfg_len` 64-bit data/parameter word pairs from two buffer read ports and drives them into the add tree.
- Sign-extends and accumulates the 19-bit tree results into one ACC_W dot-product result.
- Returns the result through a valid/ready handshake.

---
 rtl/npu_add_tree_feeder.sv | 193 +++++++++++++++++++
 tb/tb_npu_add_tree_feeder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_add_tree_feeder.sv
//==============================================================================
// Module      : npu_add_tree_feeder
// Description : Issue-side operand sequencer and dot-product accumulator for
//               the 8-lane int8 add tree. Optional macro NPU_FEED_SAT_EN
//               enables saturating accumulation.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module npu_add_tree_feeder #(
   parameter int TREE_LAT = 1,
   parameter int ADDR_W   = 10,
   parameter int LEN_W    = 8,
   parameter int ACC_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [ADDR_W-1:0] cfg_dat_base,
   input  logic [ADDR_W-1:0] cfg_par_base,
   input  logic              cfg_signed,
   output logic              busy,
   output logic              dat_rd_en,
   output logic [ADDR_W-1:0] dat_rd_addr,
   input  logic [63:0]       dat_rd_data,
   output logic              par_rd_en,
   output logic [ADDR_W-1:0] par_rd_addr,
   input  logic [63:0]       par_rd_data,
   output logic [63:0]       add_tree_data,
   output logic [63:0]       add_tree_para,
   output logic              is_signed_data,
   input  logic [18:0]       add_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data
);

   localparam int               c_TAG_DEPTH = 2 + TREE_LAT;
   localparam logic [LEN_W-1:0] c_LEN_ONE   = 1;
   localparam logic [ADDR_W-1:0] c_ADDR_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [LEN_W-1:0]       r_len;
   logic [LEN_W-1:0]       r_iss_cnt;
   logic [LEN_W-1:0]       r_done_cnt;
   logic [ADDR_W-1:0]      r_dat_addr;
   logic [ADDR_W-1:0]      r_par_addr;
   logic                   r_signed;
   logic [c_TAG_DEPTH-1:0] r_tag;
   logic [63:0]            r_tree_dat;
   logic [63:0]            r_tree_par;
   logic [ACC_W-1:0]       r_acc;
   logic [ACC_W-1:0]       r_res_data;
   logic                   r_res_valid;

   logic             w_accept, w_issue, w_finish, w_hs;
   logic             w_tag_exit;
   logic [ACC_W-1:0] w_addend, w_sum, w_acc_nxt;

   assign w_tag_exit = r_tag[c_TAG_DEPTH-1];
   assign w_addend   = ACC_W'($signed(add_result));
   assign w_sum      = r_acc + w_addend;

`ifdef NPU_FEED_SAT_EN
   localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Overflow only when both operands share a sign the result lacks.
   always_comb begin
      w_acc_nxt = w_sum;
      if ((r_acc[ACC_W-1] == w_addend[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
         w_acc_nxt = r_acc[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX;
   end
`else
   assign w_acc_nxt = w_sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_finish    = 1'b0;
      w_hs        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = (cfg_len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_issue = 1'b1;
            if (r_iss_cnt == r_len - c_LEN_ONE) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Publish on the edge the last tag retires so the result is not delayed a cycle.
            if (w_tag_exit && (r_done_cnt == r_len - c_LEN_ONE)) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (r_res_valid && res_ready) begin
               w_hs        = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len       <= '0;
         r_iss_cnt   <= '0;
         r_done_cnt  <= '0;
         r_dat_addr  <= '0;
         r_par_addr  <= '0;
         r_signed    <= 1'b0;
         r_tag       <= '0;
         r_tree_dat  <= '0;
         r_tree_par  <= '0;
         r_acc       <= '0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_tag      <= {r_tag[c_TAG_DEPTH-2:0], w_issue};
         r_tree_dat <= r_tag[0] ? dat_rd_data : 64'd0;
         r_tree_par <= r_tag[0] ? par_rd_data : 64'd0;

         if (w_accept) begin
            r_len      <= cfg_len;
            r_dat_addr <= cfg_dat_base;
            r_par_addr <= cfg_par_base;
            r_signed   <= cfg_signed;
            r_acc      <= '0;
            r_iss_cnt  <= '0;
            r_done_cnt <= '0;
            if (cfg_len == '0) begin
               r_res_data  <= '0;
               r_res_valid <= 1'b1;
            end
         end

         if (w_issue) begin
            r_dat_addr <= r_dat_addr + c_ADDR_ONE;
            r_par_addr <= r_par_addr + c_ADDR_ONE;
            r_iss_cnt  <= r_iss_cnt + c_LEN_ONE;
         end

         if (w_tag_exit) begin
            r_acc      <= w_acc_nxt;
            r_done_cnt <= r_done_cnt + c_LEN_ONE;
         end

         if (w_finish) begin
            r_res_data  <= w_acc_nxt;
            r_res_valid <= 1'b1;
         end

         if (w_hs) r_res_valid <= 1'b0;
      end
   end

   assign busy           = (r_state != S_IDLE);
   assign dat_rd_en      = (r_state == S_ISSUE);
   assign par_rd_en      = (r_state == S_ISSUE);
   assign dat_rd_addr    = r_dat_addr;
   assign par_rd_addr    = r_par_addr;
   assign add_tree_data  = r_tree_dat;
   assign add_tree_para  = r_tree_par;
   assign is_signed_data = r_signed;
   assign res_valid      = r_res_valid;
   assign res_data       = r_res_data;

endmodule

`default_nettype wire

// File: tb/tb_npu_add_tree_feeder.sv
//==============================================================================
// Module      : tb_npu_add_tree_feeder
// Description : Directed self-checking bench; a 32-bit and a 20-bit
//               accumulator instance share stimulus and buffer contents.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_npu_add_tree_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  cfg_len = '0;
   logic [9:0]  cfg_dat_base = '0;
   logic [9:0]  cfg_par_base = '0;
   logic        cfg_signed = 1'b0;
   logic        res_ready = 1'b0;

   logic        busy, dat_rd_en, par_rd_en, is_signed_data, res_valid;
   logic [9:0]  dat_rd_addr, par_rd_addr;
   logic [63:0] dat_rd_data = '0, par_rd_data = '0, add_tree_data, add_tree_para;
   logic [18:0] add_result = '0;
   logic [31:0] res_data;

   logic        s_busy, s_dat_rd_en, s_par_rd_en, s_is_signed_data, s_res_valid;
   logic [9:0]  s_dat_rd_addr, s_par_rd_addr;
   logic [63:0] s_dat_rd_data = '0, s_par_rd_data = '0, s_add_tree_data, s_add_tree_para;
   logic [18:0] s_add_result = '0;
   logic [19:0] s_res_data;

   logic [63:0] dmem [0:1023];
   logic [63:0] pmem [0:1023];
   logic [9:0]  addr_log [0:15];
   int          naddr;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   npu_add_tree_feeder #(.TREE_LAT(1), .ADDR_W(10), .LEN_W(8), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .cfg_dat_base(cfg_dat_base), .cfg_par_base(cfg_par_base), .cfg_signed(cfg_signed),
      .busy(busy), .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data),
      .par_rd_en(par_rd_en), .par_rd_addr(par_rd_addr), .par_rd_data(par_rd_data),
      .add_tree_data(add_tree_data), .add_tree_para(add_tree_para),
      .is_signed_data(is_signed_data), .add_result(add_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   npu_add_tree_feeder #(.TREE_LAT(1), .ADDR_W(10), .LEN_W(8), .ACC_W(20)) dut_s (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .cfg_dat_base(cfg_dat_base), .cfg_par_base(cfg_par_base), .cfg_signed(cfg_signed),
      .busy(s_busy), .dat_rd_en(s_dat_rd_en), .dat_rd_addr(s_dat_rd_addr), .dat_rd_data(s_dat_rd_data),
      .par_rd_en(s_par_rd_en), .par_rd_addr(s_par_rd_addr), .par_rd_data(s_par_rd_data),
      .add_tree_data(s_add_tree_data), .add_tree_para(s_add_tree_para),
      .is_signed_data(s_is_signed_data), .add_result(s_add_result),
      .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data)
   );

   // Reference 8-lane int8 dot product, 19-bit two's-complement result.
   function automatic logic [18:0] tree(input logic [63:0] d, input logic [63:0] p, input logic sg);
      int s, dv, pv;
      s = 0;
      for (int i = 0; i < 8; i++) begin
         dv = sg ? int'($signed(d[8*i +: 8])) : int'(d[8*i +: 8]);
         pv = int'($signed(p[8*i +: 8]));
         s  = s + dv * pv;
      end
      return s[18:0];
   endfunction

   always @(posedge clk) begin
      if (dat_rd_en)   dat_rd_data   <= dmem[dat_rd_addr];
      if (par_rd_en)   par_rd_data   <= pmem[par_rd_addr];
      if (s_dat_rd_en) s_dat_rd_data <= dmem[s_dat_rd_addr];
      if (s_par_rd_en) s_par_rd_data <= pmem[s_par_rd_addr];
      add_result   <= tree(add_tree_data, add_tree_para, is_signed_data);
      s_add_result <= tree(s_add_tree_data, s_add_tree_para, s_is_signed_data);
   end

   task automatic do_job(input int len, input logic [9:0] db, input logic [9:0] pb,
                         input logic sg, output int vcyc);
      @(negedge clk);
      cfg_len = len[7:0]; cfg_dat_base = db; cfg_par_base = pb; cfg_signed = sg; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; cfg_len = 8'hA5; cfg_dat_base = 10'h155; cfg_par_base = 10'h2AA; cfg_signed = ~sg;
      naddr = 0;
      vcyc  = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (dat_rd_en) begin
            if (naddr < 16) addr_log[naddr] = dat_rd_addr;
            naddr++;
         end
         if (res_valid) begin
            vcyc = c;
            break;
         end
      end
      total++;
      if (vcyc == 0) begin
         bad++;
         $display("FAIL job_timeout: res_valid never rose, required within 60 cycles");
      end
   endtask

   task automatic finish_hs();
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, res_valid} !== 2'b00) begin
         bad++;
         $display("FAIL hs_idle: busy/res_valid=%b required 00", {busy, res_valid});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, dat_rd_en, par_rd_en, res_valid, is_signed_data} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctl: got %b required 00000", {busy, dat_rd_en, par_rd_en, res_valid, is_signed_data});
      end
      total++;
      if ({dat_rd_addr, par_rd_addr, add_tree_data, add_tree_para, res_data} !== '0) begin
         bad++;
         $display("FAIL reset_data: addr %h/%h tree %h/%h res %h required all 0",
                  dat_rd_addr, par_rd_addr, add_tree_data, add_tree_para, res_data);
      end
   endtask

   task automatic test_basic();
      int v;
      dmem[5] = 64'h0101010101010101;
      pmem[9] = 64'h0202020202020202;
      do_job(1, 10'd5, 10'd9, 1'b1, v);
      total++;
      if (v !== 5) begin bad++; $display("FAIL basic_latency: got %0d required 5", v); end
      total++;
      if (res_data !== 32'd16) begin bad++; $display("FAIL basic_result: got %0d required 16", res_data); end
      total++;
      if (naddr !== 1 || addr_log[0] !== 10'd5) begin
         bad++;
         $display("FAIL basic_addr: count %0d first %h required 1 / 005", naddr, addr_log[0]);
      end
      finish_hs();
   endtask

   task automatic test_signedness();
      int v;
      for (int i = 0; i < 4; i++) begin
         dmem[10'h20 + i] = {8{8'hFF}};
         pmem[10'h40 + i] = {8{8'h7F}};
      end
      do_job(4, 10'h20, 10'h40, 1'b1, v);
      total++;
      if (v !== 8) begin bad++; $display("FAIL signed_latency: got %0d required 8", v); end
      total++;
      if ($signed(res_data) !== -4064) begin
         bad++; $display("FAIL signed_result: got %0d required -4064", $signed(res_data));
      end
      total++;
      if ($signed(s_res_data) !== -4064) begin
         bad++; $display("FAIL signed_result_acc20: got %0d required -4064", $signed(s_res_data));
      end
      finish_hs();
      do_job(4, 10'h20, 10'h40, 1'b0, v);
      total++;
      if (res_data !== 32'd1036320) begin
         bad++; $display("FAIL unsigned_result: got %0d required 1036320", res_data);
      end
`ifdef NPU_FEED_SAT_EN
      total++;
      if ($signed(s_res_data) !== 524287) begin
         bad++; $display("FAIL sat_acc20: got %0d required 524287", $signed(s_res_data));
      end
`else
      total++;
      if ($signed(s_res_data) !== -12256) begin
         bad++; $display("FAIL wrap_acc20: got %0d required -12256", $signed(s_res_data));
      end
`endif
      finish_hs();
   endtask

   task automatic test_addr_wrap();
      int v;
      logic [9:0] exp_addr [0:3];
      exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
      for (int i = 0; i < 4; i++) begin
         dmem[exp_addr[i]] = {8{8'(i + 1)}};
         pmem[10'h10 + i]  = {8{8'h01}};
      end
      do_job(4, 10'h3FE, 10'h010, 1'b1, v);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (addr_log[i] !== exp_addr[i]) begin
            bad++; $display("FAIL wrap_addr%0d: got %h required %h", i, addr_log[i], exp_addr[i]);
         end
      end
      total++;
      if (res_data !== 32'd80) begin bad++; $display("FAIL wrap_result: got %0d required 80", res_data); end
      finish_hs();
   endtask

   task automatic test_len0();
      int v;
      do_job(0, 10'h100, 10'h100, 1'b1, v);
      total++;
      if (v !== 1) begin bad++; $display("FAIL len0_latency: got %0d required 1", v); end
      total++;
      if (res_data !== 32'd0 || naddr !== 0) begin
         bad++; $display("FAIL len0_result: res %0d reads %0d required 0 and 0", res_data, naddr);
      end
      finish_hs();
   endtask

   task automatic test_backpressure();
      int v;
      do_job(1, 10'd5, 10'd9, 1'b1, v);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({res_valid, busy} !== 2'b11 || res_data !== 32'd16) begin
            bad++;
            $display("FAIL hold_%0d: valid/busy %b res %0d required 11 / 16", i, {res_valid, busy}, res_data);
         end
         start = (i % 3 == 0); cfg_len = 8'd0;
      end
      @(negedge clk);
      start = 1'b1; cfg_len = 8'd1; cfg_dat_base = 10'd5; cfg_par_base = 10'd9; res_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, dat_rd_en, res_valid} !== 3'b000) begin
         bad++; $display("FAIL hs_start_ignored: busy/rd_en/valid %b required 000", {busy, dat_rd_en, res_valid});
      end
      do_job(1, 10'd5, 10'd9, 1'b1, v);
      total++;
      if (v !== 5 || res_data !== 32'd16) begin
         bad++; $display("FAIL after_hs_job: cycle %0d res %0d required 5 / 16", v, res_data);
      end
      finish_hs();
   endtask

   task automatic test_reset_mid();
      int v;
      for (int i = 0; i < 8; i++) begin
         dmem[10'h80 + i] = {8{8'h01}};
         pmem[10'h80 + i] = {8{8'h03}};
      end
      @(negedge clk);
      cfg_len = 8'd8; cfg_dat_base = 10'h80; cfg_par_base = 10'h80; cfg_signed = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy, dat_rd_en, par_rd_en, res_valid, is_signed_data} !== 5'b0) begin
         bad++; $display("FAIL midreset_ctl: got %b required 00000", {busy, dat_rd_en, par_rd_en, res_valid, is_signed_data});
      end
      total++;
      if ({dat_rd_addr, add_tree_data, add_tree_para, res_data} !== '0) begin
         bad++; $display("FAIL midreset_data: addr %h tree %h/%h res %h required 0",
                         dat_rd_addr, add_tree_data, add_tree_para, res_data);
      end
      @(negedge clk);
      rst = 1'b0;
      do_job(1, 10'd5, 10'd9, 1'b1, v);
      total++;
      if (v !== 5 || res_data !== 32'd16) begin
         bad++; $display("FAIL midreset_next_job: cycle %0d res %0d required 5 / 16", v, res_data);
      end
      finish_hs();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         dmem[i] = '0;
         pmem[i] = '0;
      end
      test_reset();
      test_basic();
      test_signedness();
      test_addr_wrap();
      test_len0();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
